wt_cache_ctrl: RTL

Sequencing controller for the 32-line direct-mapped, write-through data cache array. It accepts one CPU load/store at a time and performs the tag compare against the array's valid/tag outputs. It drives the array's refill/update strobes, runs the main-memory read (block refill) and write (write-through) handshakes, and keeps hit/miss statistics. It sits between the CPU port, the cache array and the main-memory port.

---
 rtl/wt_cache_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/wt_cache_ctrl.sv
// Sequencing controller for a direct-mapped, write-through, no-write-allocate data cache.
// Does the tag compare, drives array refill/update strobes, runs memory handshakes, keeps hit/miss stats.
module wt_cache_ctrl #(
    parameter int TAG_W    = 3,
    parameter int INDEX_W  = 5,
    parameter int OFFSET_W = 2,
    parameter int CNT_W    = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   cpu_req,
    input  logic                                   cpu_we,
    input  logic [TAG_W+INDEX_W+OFFSET_W-1:0]      cpu_addr,
    input  logic [31:0]                            cpu_wdata,
    output logic                                   cpu_ready,
    output logic                                   cpu_done,
    output logic [31:0]                            cpu_rdata,
    output logic [INDEX_W-1:0]                     arr_index,
    output logic [OFFSET_W-1:0]                    arr_offset,
    output logic [TAG_W-1:0]                       arr_tag,
    output logic [31:0]                            arr_wdata,
    output logic                                   arr_refill,
    output logic                                   arr_update,
    input  logic                                   arr_valid,
    input  logic [TAG_W-1:0]                       arr_tag_q,
    input  logic [31:0]                            arr_rdata,
    output logic                                   mem_rd_req,
    output logic                                   mem_wr_req,
    output logic [TAG_W+INDEX_W+OFFSET_W-1:0]      mem_addr,
    output logic [31:0]                            mem_wdata,
    input  logic [(32<<OFFSET_W)-1:0]              mem_rdata,
    input  logic                                   mem_ack,
    output logic [CNT_W-1:0]                       rd_hit_cnt,
    output logic [CNT_W-1:0]                       rd_miss_cnt,
    output logic [CNT_W-1:0]                       wr_hit_cnt,
    output logic [CNT_W-1:0]                       wr_miss_cnt
);
    localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;
    localparam int NWORDS = 1 << OFFSET_W;

    typedef enum logic [2:0] {
        IDLE, COMPARE, MEM_RD, REFILL, UPDATE, MEM_WR, DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg;
    logic                we_reg;
    logic [31:0]         wdata_reg;
    logic [31:0]         rdata_reg, rdata_next;
    logic [3:0]          cnt_inc;
    logic [CNT_W-1:0]    cnt_reg [4];
    logic [31:0]         blk_word [NWORDS];
    logic                hit;
    logic                latch_req;

    wire [TAG_W-1:0]    addr_tag = addr_reg[ADDR_W-1 -: TAG_W];
    wire [INDEX_W-1:0]  addr_idx = addr_reg[OFFSET_W +: INDEX_W];
    wire [OFFSET_W-1:0] addr_off = addr_reg[OFFSET_W-1:0];

    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
            assign blk_word[gi] = mem_rdata[gi*32 +: 32];
        end
    endgenerate

    assign hit = arr_valid && (arr_tag_q == addr_tag);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            rdata_reg <= rdata_next;
            if (latch_req) begin
                addr_reg  <= cpu_addr;
                we_reg    <= cpu_we;
                wdata_reg <= cpu_wdata;
            end
        end
    end

    // cnt_inc bit order: read hit, read miss, write hit, write miss
    always_comb begin
        state_next = state_reg;
        rdata_next = rdata_reg;
        cnt_inc    = '0;
        latch_req  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cpu_req) begin
                    latch_req  = 1'b1;
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                if (!we_reg) begin
                    if (hit) begin
                        rdata_next = arr_rdata;
                        cnt_inc[0] = 1'b1;
                        state_next = DONE;
                    end else begin
                        cnt_inc[1] = 1'b1;
                        state_next = MEM_RD;
                    end
                end else if (hit) begin
                    cnt_inc[2] = 1'b1;
                    state_next = UPDATE;
                end else begin
                    cnt_inc[3] = 1'b1;
                    state_next = MEM_WR;
                end
            end
            MEM_RD: begin
                if (mem_ack) begin
                    rdata_next = blk_word[addr_off];
                    state_next = REFILL;
                end
            end
            REFILL:  state_next = DONE;
            UPDATE:  state_next = MEM_WR;
            MEM_WR:  if (mem_ack) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    cnt_reg[gi] <= '0;
                else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}}))
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
            end
        end
    endgenerate

    // Refill reads the whole block, so the offset is forced to word 0
    always_comb begin
        mem_addr = '0;
        if (state_reg == MEM_RD)
            mem_addr = {addr_tag, addr_idx, {OFFSET_W{1'b0}}};
        else if (state_reg == MEM_WR)
            mem_addr = addr_reg;
    end

    assign cpu_ready   = (state_reg == IDLE);
    assign cpu_done    = (state_reg == DONE);
    assign cpu_rdata   = rdata_reg;
    assign arr_index   = addr_idx;
    assign arr_offset  = addr_off;
    assign arr_tag     = addr_tag;
    assign arr_wdata   = wdata_reg;
    assign arr_refill  = (state_reg == REFILL);
    assign arr_update  = (state_reg == UPDATE);
    assign mem_rd_req  = (state_reg == MEM_RD);
    assign mem_wr_req  = (state_reg == MEM_WR);
    assign mem_wdata   = wdata_reg;
    assign rd_hit_cnt  = cnt_reg[0];
    assign rd_miss_cnt = cnt_reg[1];
    assign wr_hit_cnt  = cnt_reg[2];
    assign wr_miss_cnt = cnt_reg[3];

endmodule
